divider_nr_param: RTL

Parametrised non-restoring integer divider for the M-extension execute stage. It executes DIV/DIVU/REM/REMU on XLEN-bit operands and retires BITS_PER_CYCLE quotient bits per cycle. It has its own internal adder and does not share the ALU. It talks to the issue logic through a valid/ready request channel and to writeback through a valid/ready response channel, and it supports pipeline flush.

---
 rtl/divider_nr_param.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/divider_nr_param.sv
// Iterative non-restoring divider for DIV/DIVU/REM/REMU. It retires BITS_PER_CYCLE
// quotient bits per cycle and uses valid/ready request and response channels.
module divider_nr_param #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic            busy_o
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t                 state;
    logic [1:0]             funct3_q;
    logic [XLEN-1:0]        a_q;
    logic [XLEN-1:0]        b_q;
    logic signed [XLEN:0]   rem_q;
    logic [XLEN-1:0]        quo_q;
    logic [XLEN-1:0]        dvs_q;
    logic                   neg_q_q;
    logic                   neg_r_q;
    logic [CW-1:0]          cnt_q;
    logic [XLEN-1:0]        result_q;

    logic                   accept;
    logic                   is_signed;
    logic                   a_neg;
    logic                   b_neg;
    logic [XLEN-1:0]        a_mag;
    logic [XLEN-1:0]        b_mag;
    logic                   div_by_zero;
    logic                   sig_ovf;
    logic signed [XLEN:0]   d_ext;
    logic signed [XLEN:0]   r_it;
    logic signed [XLEN:0]   r_sh;
    logic [XLEN-1:0]        q_it;
    logic [XLEN-1:0]        rem_mag;
    logic [XLEN-1:0]        quo_res;
    logic [XLEN-1:0]        rem_res;
    logic [XLEN-1:0]        fix_result;
    logic                   unused_funct3;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        cond_neg = n ? (~v + XLEN'(1)) : v;
    endfunction

    assign unused_funct3 = funct3_i[2];

    assign req_ready_o   = ~flush_i & ((state == IDLE) | ((state == DONE) & resp_ready_i));
    assign accept        = req_valid_i & req_ready_o;
    assign resp_valid_o  = (state == DONE);
    assign busy_o        = (state != IDLE);
    assign resp_result_o = result_q;

    // prep: operand magnitudes and special-case detection
    assign is_signed   = ~funct3_q[0];
    assign a_neg       = is_signed & a_q[XLEN-1];
    assign b_neg       = is_signed & b_q[XLEN-1];
    assign a_mag       = cond_neg(a_q, a_neg);
    assign b_mag       = cond_neg(b_q, b_neg);
    assign div_by_zero = (b_q == '0);
    assign sig_ovf     = is_signed & (a_q == MIN_VAL) & (b_q == '1);

    // iter: sign test uses the pre-shift remainder, so the wrap of 2R is harmless
    assign d_ext = $signed({1'b0, dvs_q});

    always_comb begin
        r_it = rem_q;
        q_it = quo_q;
        r_sh = '0;
        for (int s = 0; s < BITS_PER_CYCLE; s++) begin
            r_sh = {r_it[XLEN-1:0], q_it[XLEN-1]};
            q_it = {q_it[XLEN-2:0], 1'b0};
            if (r_it[XLEN]) begin
                r_it = r_sh + d_ext;
            end else begin
                r_it = r_sh - d_ext;
            end
            q_it[0] = ~r_it[XLEN];
        end
    end

    // fix: final remainder restore and sign application
    assign rem_mag    = rem_q[XLEN] ? (rem_q[XLEN-1:0] + dvs_q) : rem_q[XLEN-1:0];
    assign quo_res    = cond_neg(quo_q, neg_q_q);
    assign rem_res    = cond_neg(rem_mag, neg_r_q);
    assign fix_result = funct3_q[1] ? rem_res : quo_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else if (accept) begin
            funct3_q <= funct3_i[1:0];
            a_q      <= op_a_i;
            b_q      <= op_b_i;
            state    <= PREP;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                PREP: begin
                    neg_q_q <= a_neg ^ b_neg;
                    neg_r_q <= a_neg;
                    if (div_by_zero) begin
                        result_q <= funct3_q[1] ? a_q : '1;
                        state    <= DONE;
                    end else if (sig_ovf) begin
                        result_q <= funct3_q[1] ? '0 : MIN_VAL;
                        state    <= DONE;
                    end else begin
                        rem_q <= '0;
                        quo_q <= a_mag;
                        dvs_q <= b_mag;
                        cnt_q <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem_q <= r_it;
                    quo_q <= q_it;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_result;
                    state    <= DONE;
                end
                DONE: begin
                    if (resp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
